// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state type, 8N1 frame constants
// and the default bit divisor used by both the transmitter and receiver.
package uart_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        TRANSMIT = 1'b1
    } tx_state_t;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

    // 12'hA2C = 2604 clocks per bit
    localparam logic [11:0] DEFAULT_BAUD_DIV = 12'hA2C;

    // Shift-register image of a fresh frame: start bit (0) in bit 0, data above it.
    function automatic logic [DATA_BITS:0] frame_load(input logic [DATA_BITS-1:0] data);
        return {data, 1'b0};
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Reload down-counter producing one tick per bit period. Reloads DIV-1 on
// load or on a tick, counts down while enabled, never underflows.
module uart_baud_gen #(
    parameter logic [11:0] DIV = 12'hA2C
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic tick
);

    localparam logic [11:0] RELOAD = DIV - 12'd1;

    logic [11:0] cnt_reg;
    logic [11:0] cnt_next;

    assign tick = en && (cnt_reg == 12'd0);

    // Next count: reload on load or expiry, otherwise decrement while enabled
    always_comb begin
        cnt_next = cnt_reg;
        if (load || tick) begin
            cnt_next = RELOAD;
        end else if (en) begin
            cnt_next = cnt_reg - 12'd1;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= RELOAD;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-byte holding register so that a queued
// byte follows the previous stop bit with no idle gap.
module uart_tx
    import uart_pkg::*;
#(
    parameter logic [11:0] BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 trmt,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 clr_done,
    output logic                 TX,
    output logic                 tx_full,
    output logic                 tx_done
);

    tx_state_t            state_reg;
    tx_state_t            state_next;
    logic [DATA_BITS:0]   shift_reg;
    logic [DATA_BITS-1:0] hold_reg;
    logic [3:0]           bit_cnt_reg;
    logic                 full_reg;
    logic                 full_next;
    logic                 done_reg;
    logic                 done_next;

    logic baud_tick;
    logic shift;
    logic frame_end;
    logic load_direct;
    logic load_hold;
    logic capture;
    logic set_done;
    logic idle_accept;

    uart_baud_gen #(
        .DIV (BAUD_DIV)
    ) u_baud_gen (
        .clk  (clk),
        .rst  (rst),
        .load (load_direct || load_hold),
        .en   (state_reg == TRANSMIT),
        .tick (baud_tick)
    );

    assign shift     = (state_reg == TRANSMIT) && baud_tick;
    // Tenth shift of a frame closes the stop bit
    assign frame_end = shift && (bit_cnt_reg == 4'(FRAME_BITS - 1));

    // Next-state, load selection and flag updates
    always_comb begin
        state_next  = state_reg;
        load_direct = 1'b0;
        load_hold   = 1'b0;
        capture     = 1'b0;
        set_done    = 1'b0;
        idle_accept = 1'b0;
        full_next   = full_reg;
        done_next   = done_reg;

        case (state_reg)
            IDLE: begin
                if (trmt) begin
                    load_direct = 1'b1;
                    idle_accept = 1'b1;
                    state_next  = TRANSMIT;
                end
            end
            TRANSMIT: begin
                if (frame_end) begin
                    if (full_reg) begin
                        // Queued byte goes straight out; trmt this cycle is dropped
                        load_hold = 1'b1;
                        full_next = 1'b0;
                    end else if (trmt) begin
                        // Byte arriving on the last stop-bit cycle is loaded directly
                        load_direct = 1'b1;
                    end else begin
                        state_next = IDLE;
                        set_done   = 1'b1;
                    end
                end else if (trmt && !full_reg) begin
                    capture   = 1'b1;
                    full_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (set_done) begin
            done_next = 1'b1;
        end else if (clr_done || idle_accept) begin
            done_next = 1'b0;
        end
    end

    // State and flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            full_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            full_reg  <= full_next;
            done_reg  <= done_next;
        end
    end

    // Shift register: loads take priority over the shift on the same tick
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= '1;
        end else if (load_direct) begin
            shift_reg <= frame_load(tx_data);
        end else if (load_hold) begin
            shift_reg <= frame_load(hold_reg);
        end else if (shift) begin
            shift_reg <= {1'b1, shift_reg[DATA_BITS:1]};
        end
    end

    // Bit counter: clears on every frame load, counts shifts up to FRAME_BITS
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_reg <= 4'd0;
        end else if (load_direct || load_hold) begin
            bit_cnt_reg <= 4'd0;
        end else if (shift) begin
            bit_cnt_reg <= bit_cnt_reg + 4'd1;
        end
    end

    // Holding register for the byte queued behind the current frame
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_reg <= '0;
        end else if (capture) begin
            hold_reg <= tx_data;
        end
    end

    assign TX      = shift_reg[0];
    assign tx_full = full_reg;
    assign tx_done = done_reg;

endmodule
